// File: rtl/hack_alu_serial.sv
// Digit-serial Hack ALU: accepts one operation, evaluates zx/nx/zy/ny/f/no DIGIT bits per
// cycle and holds a registered result (out/zr/ng/cy) until the consumer takes it.
module hack_alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic             init_q;
  logic [WIDTH-1:0] xs_q, ys_q, acc_q, out_q;
  logic             f_q, no_q, carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zr_q, ng_q, cy_q;

  logic             fire, cnt_last, done_entry;
  logic [WIDTH-1:0] x_zero, x_prep, y_zero, y_prep;
  logic [DIGIT-1:0] x_dig, y_dig, dig, dig_o;
  logic [DIGIT:0]   dig_sum;
  logic             carry_d;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0] acc_d;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire)      state_d = RUN;
      RUN:     if (cnt_last)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (init_q holds in_ready low until the first edge after reset)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = init_q;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign fire       = in_valid && in_ready;
  assign cnt_last   = (cnt_q == CNT_W'(N - 1));
  assign done_entry = (state_q == RUN) && cnt_last;

  // Operand conditioning applied once, at accept time.
  assign x_zero = zx ? '0 : x;
  assign x_prep = nx ? ~x_zero : x_zero;
  assign y_zero = zy ? '0 : y;
  assign y_prep = ny ? ~y_zero : y_zero;

  // One digit step; carry only moves on adds, so it stays 0 for f=0 operations.
  assign x_dig   = xs_q[DIGIT-1:0];
  assign y_dig   = ys_q[DIGIT-1:0];
  assign dig_sum = {1'b0, x_dig} + {1'b0, y_dig} + {{DIGIT{1'b0}}, carry_q};
  assign dig     = f_q ? dig_sum[DIGIT-1:0] : (x_dig & y_dig);
  assign dig_o   = dig ^ {DIGIT{no_q}};
  assign carry_d = f_q ? dig_sum[DIGIT] : carry_q;

  // Result fills from the MSB end; after N digits the first digit sits at the LSB.
  assign acc_cat = {dig_o, acc_q};
  assign acc_d   = acc_cat[WIDTH+DIGIT-1:DIGIT];

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      f_q     <= 1'b0;
      no_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      if (fire) begin
        xs_q    <= x_prep;
        ys_q    <= y_prep;
        f_q     <= f;
        no_q    <= no;
        carry_q <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        xs_q    <= xs_q >> DIGIT;
        ys_q    <= ys_q >> DIGIT;
        acc_q   <= acc_d;
        carry_q <= carry_d;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (done_entry) begin
        out_q <= acc_d;
        zr_q  <= (acc_d == '0);
        ng_q  <= acc_d[WIDTH-1];
        cy_q  <= carry_d;
      end
    end
  end

  assign out = out_q;
  assign zr  = zr_q;
  assign ng  = ng_q;
  assign cy  = cy_q;

endmodule

// File: tb/tb_hack_alu_serial.sv
// Directed bench for hack_alu_serial: a 16/4 instance for protocol and function,
// plus an 8/1 instance for the bit-serial corner.
module tb_hack_alu_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit, 4-bit digit instance; controls packed as {zx,nx,zy,ny,f,no}
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_x, a_y, a_res;
  logic [5:0]  a_ctl;
  logic        a_zr, a_ng, a_cy;

  // 8-bit, 1-bit digit instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_x, b_y, b_res;
  logic [5:0]  b_ctl;
  logic        b_zr, b_ng, b_cy;

  int checks = 0;
  int errors = 0;

  hack_alu_serial #(.WIDTH(16), .DIGIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y),
    .zx(a_ctl[5]), .nx(a_ctl[4]), .zy(a_ctl[3]), .ny(a_ctl[2]), .f(a_ctl[1]), .no(a_ctl[0]),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_res), .zr(a_zr), .ng(a_ng), .cy(a_cy)
  );

  hack_alu_serial #(.WIDTH(8), .DIGIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y),
    .zx(b_ctl[5]), .nx(b_ctl[4]), .zy(b_ctl[3]), .ny(b_ctl[2]), .f(b_ctl[1]), .no(b_ctl[0]),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_res), .zr(b_zr), .ng(b_ng), .cy(b_cy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Offer one op on instance A, return cycles from accept edge to out_valid.
  task automatic run_a(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c,
                       output int lat, output bit to);
    int n;
    n   = 0;
    lat = 0;
    to  = 1'b0;
    while (!a_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!a_in_ready) begin
      to = 1'b1;
      return;
    end
    a_x = xv; a_y = yv; a_ctl = c; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!a_out_valid) to = 1'b1;
  endtask

  task automatic take_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_x = '0; a_y = '0; a_ctl = '0;
    b_in_valid = 0; b_out_ready = 0; b_x = '0; b_y = '0; b_ctl = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_res, a_zr, a_ng, a_cy} !== 21'h0) begin
      errors++;
      $display("FAIL reset_a: got rdy=%b vld=%b out=%h zr/ng/cy=%b%b%b expected all 0",
               a_in_ready, a_out_valid, a_res, a_zr, a_ng, a_cy);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_res, b_zr, b_ng, b_cy} !== 13'h0) begin
      errors++;
      $display("FAIL reset_b: got rdy=%b vld=%b out=%h expected all 0", b_in_ready, b_out_valid, b_res);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 0", a_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got a=%b b=%b expected 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_add_latency();
    int lat; bit to;
    run_a(16'h0000, 16'hFFFF, 6'b110010, lat, to);
    checks++;
    if (to || lat != 4) begin
      errors++;
      $display("FAIL add_latency: got %0d (timeout=%b) expected 4", lat, to);
    end
    checks++;
    if ({a_res, a_zr, a_ng, a_cy} !== {16'hFFFE, 3'b011}) begin
      errors++;
      $display("FAIL add_result: got out=%h zr/ng/cy=%b%b%b expected FFFE 011", a_res, a_zr, a_ng, a_cy);
    end
    take_a();
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_handshake: got vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    run_a(16'h0011, 16'h0003, 6'b000010, lat, to);
    checks++;
    if (to || lat != 4 || {a_res, a_zr, a_ng, a_cy} !== {16'h0014, 3'b000}) begin
      errors++;
      $display("FAIL b2b_add: got out=%h flags=%b%b%b lat=%0d expected 0014 000 4",
               a_res, a_zr, a_ng, a_cy, lat);
    end
    take_a();
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready1: got %b expected 1", a_in_ready);
    end
    run_a(16'h0011, 16'h0003, 6'b010101, lat, to);
    checks++;
    if (to || lat != 4 || {a_res, a_zr, a_ng, a_cy} !== {16'h0013, 3'b000}) begin
      errors++;
      $display("FAIL b2b_and: got out=%h flags=%b%b%b lat=%0d expected 0013 000 4",
               a_res, a_zr, a_ng, a_cy, lat);
    end
    take_a();
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready2: got %b expected 1", a_in_ready);
    end
  endtask

  task automatic test_all_ones();
    int lat; bit to;
    run_a(16'h0000, 16'hFFFF, 6'b111111, lat, to);
    checks++;
    if (to || {a_res, a_zr, a_ng, a_cy} !== {16'h0001, 3'b001}) begin
      errors++;
      $display("FAIL all_ones: got out=%h flags=%b%b%b expected 0001 001", a_res, a_zr, a_ng, a_cy);
    end
    take_a();
    run_a(16'h1234, 16'h5678, 6'b101000, lat, to);
    checks++;
    if (to || {a_res, a_zr, a_ng, a_cy} !== {16'h0000, 3'b100}) begin
      errors++;
      $display("FAIL zero_result: got out=%h flags=%b%b%b expected 0000 100", a_res, a_zr, a_ng, a_cy);
    end
    take_a();
  endtask

  task automatic test_backpressure();
    int lat; bit to; int bad;
    run_a(16'h8000, 16'h0001, 6'b000010, lat, to);
    checks++;
    if (to || {a_res, a_zr, a_ng, a_cy} !== {16'h8001, 3'b010}) begin
      errors++;
      $display("FAIL bp_result: got out=%h flags=%b%b%b expected 8001 010", a_res, a_zr, a_ng, a_cy);
    end
    bad = 0;
    a_x = 16'h1234; a_y = 16'h4321; a_ctl = 6'b000010; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 ||
          {a_res, a_zr, a_ng, a_cy} !== {16'h8001, 3'b010}) bad++;
    end
    a_in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d disturbed cycles expected 0", bad);
    end
    take_a();
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (a_out_valid !== 1'b0 || a_res !== 16'h8001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_no_queue: got %0d cycles with a spurious result expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to; int bad;
    a_x = 16'h00FF; a_y = 16'h0F00; a_ctl = 6'b000010; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_res, a_zr, a_ng, a_cy} !== 21'h0) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b out=%h flags=%b%b%b expected all 0",
               a_in_ready, a_out_valid, a_res, a_zr, a_ng, a_cy);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (a_out_valid !== 1'b0 || a_res !== 16'h0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrun_discard: got %0d cycles with a result expected 0", bad);
    end
    run_a(16'h1234, 16'h0001, 6'b000010, lat, to);
    checks++;
    if (to || lat != 4 || {a_res, a_zr, a_ng, a_cy} !== {16'h1235, 3'b000}) begin
      errors++;
      $display("FAIL midrun_fresh: got out=%h flags=%b%b%b lat=%0d expected 1235 000 4",
               a_res, a_zr, a_ng, a_cy, lat);
    end
    take_a();
  endtask

  task automatic test_width8_serial();
    int lat;
    lat = 0;
    b_x = 8'hFF; b_y = 8'h01; b_ctl = 6'b000010; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    while (!b_out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL w8_latency: got %0d expected 8", lat);
    end
    checks++;
    if ({b_res, b_zr, b_ng, b_cy} !== {8'h00, 3'b101}) begin
      errors++;
      $display("FAIL w8_result: got out=%h flags=%b%b%b expected 00 101", b_res, b_zr, b_ng, b_cy);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL w8_handshake: got vld=%b rdy=%b expected 0 1", b_out_valid, b_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_all_ones();
    test_backpressure();
    test_reset_mid_run();
    test_width8_serial();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
